// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Holds the fetch buffer entry layout and the fetch address legality check.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A fetch address is bad when it is not word aligned or its word
  // index lies outside the memory. Checking the full index (not a
  // truncated one) stops a wrapped PC from aliasing back into memory.
  function automatic logic pc_bad(
    input logic [PC_W-1:0] pc,
    input int unsigned     words
  );
    logic [PC_W-1:0] idx;
    idx = {2'b00, pc[PC_W-1:2]};
    return (pc[1:0] != 2'b00) || (idx >= PC_W'(words));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer of {pc,instr} entries with flush.
// Ports: clk, reset, flush, push/wdata, pop, head, full, empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit; full and empty differ only
  // in whether that bit matches.
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  fetch_entry_t mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop frees the slot in the same cycle, so a full buffer may
  // still accept a push alongside it.
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE;
      if (do_pop)  rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  // Storage is not reset; masking the head keeps outputs at zero
  // whenever nothing valid is presented.
  assign head = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, addresses the combinational
// instruction memory and buffers {pc,instr} pairs towards decode.
// Ports: clk, reset, imem_pc/imem_instr (memory), redirect_valid/
// redirect_pc (branch target), id_valid/id_ready/id_pc/id_instr
// (decode handshake), fetch_fault (sticky bad-address halt).
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS = 32,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               fetch_fault
);

  logic [PC_W-1:0] fetch_pc;
  logic            fault;
  logic            full;
  logic            empty;
  logic            pop;
  logic            fetch_en;
  logic            bad;
  logic            push;
  fetch_entry_t    wdata;
  fetch_entry_t    head;

  assign imem_pc  = fetch_pc;
  assign id_valid = !empty;

  // A redirect squashes the slot decode is looking at, so a
  // concurrent handshake must not count as a transfer.
  assign pop = id_valid && id_ready && !redirect_valid;

  assign fetch_en = !fault && !redirect_valid &&
                    (!full || pop);

  assign bad  = pc_bad(fetch_pc, IMEM_WORDS);
  assign push = fetch_en && !bad;

  assign wdata = '{pc: fetch_pc, instr: imem_instr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Sticky until a redirect gives fetch a fresh target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (redirect_valid) begin
      fault <= 1'b0;
    end else if (fetch_en && bad) begin
      fault <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign id_pc       = head.pc;
  assign id_instr    = head.instr;
  assign fetch_fault = fault;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl.
// Vector table plus hand sequences for overrun and mid-stream reset.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  instr_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] idx);
    if (idx < 30'd32)
      return 32'h0000_0013 | ({2'b00, idx} << 20);
    return 32'hFFFF_FFFF;
  endfunction

  assign imem_instr = mem_word(imem_pc[31:2]);

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rv,
                      input logic [31:0] rpc, input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        ef;
    logic [31:0] eimem;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic rv, input logic [31:0] rpc,
    input logic rdy, input logic ev, input logic [31:0] epc,
    input logic ef, input logic [31:0] eimem);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ef = ef; v.eimem = eimem;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    logic [31:0] got [8];
    logic [31:0] ins [8];
    logic [31:0] rise_pc;
    logic [31:0] ei;
    int n;

    // streaming with ready high
    tbl[0]  = mk(0,0,0,1, 1,32'h00,0,32'h04);
    tbl[1]  = mk(0,0,0,1, 1,32'h04,0,32'h08);
    tbl[2]  = mk(0,0,0,1, 1,32'h08,0,32'h0C);
    tbl[3]  = mk(0,0,0,1, 1,32'h0C,0,32'h10);
    // re-reset, then stall with ready low
    tbl[4]  = mk(1,0,0,0, 0,32'h00,0,32'h00);
    tbl[5]  = mk(0,0,0,0, 1,32'h00,0,32'h04);
    tbl[6]  = mk(0,0,0,0, 1,32'h00,0,32'h08);
    tbl[7]  = mk(0,0,0,0, 1,32'h00,0,32'h08);
    tbl[8]  = mk(0,0,0,0, 1,32'h00,0,32'h08);
    tbl[9]  = mk(0,0,0,0, 1,32'h00,0,32'h08);
    tbl[10] = mk(0,0,0,0, 1,32'h00,0,32'h08);
    tbl[11] = mk(0,0,0,1, 1,32'h04,0,32'h0C);
    tbl[12] = mk(0,0,0,1, 1,32'h08,0,32'h10);
    // redirect with two buffered entries
    tbl[13] = mk(0,1,32'h44,1, 0,32'h00,0,32'h44);
    tbl[14] = mk(0,0,0,1, 1,32'h44,0,32'h48);
    tbl[15] = mk(0,0,0,1, 1,32'h48,0,32'h4C);
    // misaligned redirect faults, good redirect recovers
    tbl[16] = mk(0,1,32'h46,1, 0,32'h00,0,32'h46);
    tbl[17] = mk(0,0,0,1, 0,32'h00,1,32'h46);
    tbl[18] = mk(0,0,0,1, 0,32'h00,1,32'h46);
    tbl[19] = mk(0,1,32'h08,1, 0,32'h00,0,32'h08);
    tbl[20] = mk(0,0,0,1, 1,32'h08,0,32'h0C);
    tbl[21] = mk(0,0,0,0, 1,32'h08,0,32'h10);
    // redirect while full with a concurrent handshake
    tbl[22] = mk(0,1,32'h20,1, 0,32'h00,0,32'h20);
    tbl[23] = mk(0,0,0,1, 1,32'h20,0,32'h24);

    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_imem_pc", imem_pc, 32'd0);

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      ei = tbl[i].ev ? mem_word(tbl[i].epc[31:2]) : 32'd0;
      chk($sformatf("v%0d_valid", i), {31'd0, id_valid},
          {31'd0, tbl[i].ev});
      chk($sformatf("v%0d_pc", i), id_pc, tbl[i].epc);
      chk($sformatf("v%0d_instr", i), id_instr, ei);
      chk($sformatf("v%0d_fault", i), {31'd0, fetch_fault},
          {31'd0, tbl[i].ef});
      chk($sformatf("v%0d_imem_pc", i), imem_pc, tbl[i].eimem);
    end

    // run off the end of memory
    step(0, 1, 32'h74, 1);
    n = 0;
    rise_pc = 32'hFFFF_FFFF;
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 0, 1);
      if (id_valid && n < 8) begin
        got[n] = id_pc;
        ins[n] = id_instr;
        n++;
      end
      if (fetch_fault && rise_pc == 32'hFFFF_FFFF)
        rise_pc = imem_pc;
    end
    chk("end_count", n, 3);
    if (n >= 3) begin
      chk("end_pc0", got[0], 32'h74);
      chk("end_pc1", got[1], 32'h78);
      chk("end_pc2", got[2], 32'h7C);
      chk("end_instr2", ins[2], mem_word(30'd31));
    end
    chk("end_fault", {31'd0, fetch_fault}, 32'd1);
    chk("end_rise_pc", rise_pc, 32'h80);
    chk("end_valid", {31'd0, id_valid}, 32'd0);

    // mid-stream asynchronous reset with a full buffer
    step(0, 1, 32'h0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("full_pc", id_pc, 32'h0);
    chk("full_imem_pc", imem_pc, 32'h8);
    reset = 1'b1;
    #1;
    chk("areset_valid", {31'd0, id_valid}, 32'd0);
    chk("areset_pc", id_pc, 32'd0);
    chk("areset_instr", id_instr, 32'd0);
    chk("areset_fault", {31'd0, fetch_fault}, 32'd0);
    chk("areset_imem_pc", imem_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("rel_valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_valid1", {31'd0, id_valid}, 32'd1);
    chk("rel_pc", id_pc, 32'd0);
    chk("rel_instr", id_instr, mem_word(30'd0));
    chk("rel_imem_pc", imem_pc, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
